// File: rtl/range_sweep.sv
// Sweep sequencer for the range block: launches one run, waits for done, then reads back
// every stored iteration count and reports the maximum, the n that produced it, and the sum.
module range_sweep #(
  parameter int RAM_WORDS      = 16,
  parameter int RAM_ADDR_BITS  = 4,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        req_i,
  input  logic [31:0]                 base_i,
  output logic                        busy_o,
  output logic                        result_valid_o,
  output logic                        timeout_o,
  output logic [15:0]                 max_count_o,
  output logic [31:0]                 max_n_o,
  output logic [16+RAM_ADDR_BITS-1:0] sum_count_o,
  output logic                        rgo_o,
  output logic [31:0]                 rstart_o,
  input  logic                        rdone_i,
  input  logic [15:0]                 rcount_i
);

  localparam int SUM_W = 16 + RAM_ADDR_BITS;
  localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Leaving WAIT when the incremented watchdog would reach TIMEOUT_CYCLES-1.
  localparam logic [WD_W-1:0]          WD_LAST   = WD_W'(TIMEOUT_CYCLES - 2);
  localparam logic [RAM_ADDR_BITS-1:0] ADDR_LAST = RAM_ADDR_BITS'(RAM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_READ, S_DRAIN, S_REPORT
  } state_t;

  state_t                   state_q, state_d;
  logic [31:0]              base_q;
  logic [WD_W-1:0]          wd_q;
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic [RAM_ADDR_BITS-1:0] cap_idx_q;
  logic                     cap_v_q;
  logic [15:0]              max_count_q;
  logic [31:0]              max_n_q;
  logic [SUM_W-1:0]         sum_q;
  logic                     timeout_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_i) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (rdone_i)              state_d = S_READ;
        else if (wd_q == WD_LAST) state_d = S_REPORT;
      end
      S_READ:   if (addr_q == ADDR_LAST) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_REPORT;
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o         = (state_q != S_IDLE);
    rgo_o          = (state_q == S_LAUNCH);
    result_valid_o = (state_q == S_REPORT);
    timeout_o      = (state_q == S_REPORT) && timeout_q;
    rstart_o       = '0;
    if (state_q == S_LAUNCH)    rstart_o = base_q;
    else if (state_q == S_READ) rstart_o = 32'(addr_q);
  end

  assign max_count_o = max_count_q;
  assign max_n_o     = max_n_q;
  assign sum_count_o = sum_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      base_q      <= '0;
      wd_q        <= '0;
      addr_q      <= '0;
      cap_idx_q   <= '0;
      cap_v_q     <= 1'b0;
      max_count_q <= '0;
      max_n_q     <= '0;
      sum_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      // range returns the word one cycle after the address is presented.
      cap_v_q   <= (state_q == S_READ);
      cap_idx_q <= addr_q;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            base_q      <= base_i;
            addr_q      <= '0;
            max_count_q <= '0;
            max_n_q     <= '0;
            sum_q       <= '0;
            timeout_q   <= 1'b0;
          end
        end
        S_LAUNCH: wd_q <= '0;
        S_WAIT: begin
          if (rdone_i) begin
            addr_q <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
            if (wd_q == WD_LAST) timeout_q <= 1'b1;
          end
        end
        S_READ:  addr_q <= addr_q + 1'b1;
        default: ;
      endcase
      if (cap_v_q) begin
        sum_q <= sum_q + SUM_W'(rcount_i);
        // Index 0 always seeds the maximum so all-zero sweeps report max_n = base.
        if ((cap_idx_q == '0) || (rcount_i > max_count_q)) begin
          max_count_q <= rcount_i;
          max_n_q     <= base_q + 32'(cap_idx_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_range_sweep.sv
// Scoreboard bench for range_sweep with a behavioural range stub (programmable counts,
// rdone six cycles after the rgo cycle, optional stall to force the watchdog).
module tb_range_sweep;

  logic        clk;
  logic        reset;
  logic        req;
  logic [31:0] base;
  logic        busy, result_valid, timeout;
  logic [15:0] max_count;
  logic [31:0] max_n;
  logic [19:0] sum_count;
  logic        rgo;
  logic [31:0] rstart;
  logic        rdone;
  logic [15:0] rcount;

  range_sweep #(
    .RAM_WORDS(16), .RAM_ADDR_BITS(4), .TIMEOUT_CYCLES(32)
  ) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .base_i(base),
    .busy_o(busy), .result_valid_o(result_valid), .timeout_o(timeout),
    .max_count_o(max_count), .max_n_o(max_n), .sum_count_o(sum_count),
    .rgo_o(rgo), .rstart_o(rstart), .rdone_i(rdone), .rcount_i(rcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Range stub
  logic [15:0] cnt_mem [16];
  logic        stall = 1'b0;
  int          dly = 0;
  int          rgo_cycles = 0;
  logic [31:0] launched_n = '0;
  always @(posedge clk) begin
    rcount <= cnt_mem[rstart[3:0]];
    if (rgo) begin
      dly        <= 6;
      rgo_cycles <= rgo_cycles + 1;
      launched_n <= rstart;
    end else if (dly > 0) begin
      dly <= dly - 1;
    end
  end
  assign rdone = !stall && (dly == 1);

  typedef struct {
    logic [15:0] mc;
    logic [31:0] mn;
    logic [19:0] sum;
    logic        to;
    int          req_cyc;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got result_valid=1 expected no result");
      end else begin
        e = exp_q.pop_front();
        check("max_count", 64'(max_count), 64'(e.mc));
        check("max_n",     64'(max_n),     64'(e.mn));
        check("sum_count", 64'(sum_count), 64'(e.sum));
        check("timeout",   64'(timeout),   64'(e.to));
        check("latency",   64'(cyc - e.req_cyc), 64'(e.lat));
        $display("result: max_count=%0d max_n=%0h sum=%0h timeout=%0b latency=%0d",
                 max_count, max_n, sum_count, timeout, cyc - e.req_cyc);
      end
    end
  end

  task automatic do_req(input logic [31:0] b, input logic push, input logic [15:0] mc,
                        input logic [31:0] mn, input logic [19:0] s, input logic to,
                        input int lat);
    exp_t e;
    @(posedge clk); #1;
    req  = 1'b1;
    base = b;
    if (push) begin
      e = '{mc, mn, s, to, cyc, lat};
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_wait: got no result_valid within %0d cycles expected one", budget);
      exp_q.delete();
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},      64'(busy),         64'd0);
    check({tag, "_rv"},        64'(result_valid), 64'd0);
    check({tag, "_timeout"},   64'(timeout),      64'd0);
    check({tag, "_max_count"}, 64'(max_count),    64'd0);
    check({tag, "_max_n"},     64'(max_n),        64'd0);
    check({tag, "_sum"},       64'(sum_count),    64'd0);
    check({tag, "_rgo"},       64'(rgo),          64'd0);
    check({tag, "_rstart"},    64'(rstart),       64'd0);
  endtask

  int collatz[16] = '{0, 1, 7, 2, 5, 8, 16, 3, 19, 6, 14, 9, 9, 17, 17, 4};
  int rgo_before;

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    base  = '0;
    for (int i = 0; i < 16; i++) cnt_mem[i] = '0;
    @(posedge clk); #2;
    check_cleared("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: counts[i]=i, base=100; a req while busy must be ignored
    for (int i = 0; i < 16; i++) cnt_mem[i] = 16'(i);
    rgo_before = rgo_cycles;
    do_req(32'd100, 1'b1, 16'd15, 32'd115, 20'd120, 1'b0, 25);
    repeat (3) @(posedge clk);
    #1 req = 1'b1; base = 32'd999;
    @(posedge clk); #1 req = 1'b0;
    wait_empty(100);
    check("t1_rgo_pulses", 64'(rgo_cycles - rgo_before), 64'd1);
    check("t1_launch_n", 64'(launched_n), 64'd100);

    // 2: ties keep the lowest index
    for (int i = 0; i < 16; i++) cnt_mem[i] = 16'd7;
    cnt_mem[3] = 16'd20;
    cnt_mem[9] = 16'd20;
    do_req(32'd0, 1'b1, 16'd20, 32'd3, 20'd138, 1'b0, 25);
    wait_empty(100);

    // 3: range never finishes -> watchdog
    stall = 1'b1;
    do_req(32'd50, 1'b1, 16'd0, 32'd0, 20'd0, 1'b1, 33);
    wait_empty(100);
    @(posedge clk); #1;
    check("t3_busy_after", 64'(busy), 64'd0);
    stall = 1'b0;

    // 4: collatz trajectory lengths for n=1..16
    for (int i = 0; i < 16; i++) cnt_mem[i] = 16'(collatz[i]);
    do_req(32'd1, 1'b1, 16'd19, 32'd9, 20'd137, 1'b0, 25);
    wait_empty(100);

    // 5: reset mid-READ aborts, then the same sweep again with ignored req pulses
    do_req(32'd1, 1'b0, 16'd0, 32'd0, 20'd0, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #2;
    check_cleared("midread");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    rgo_before = rgo_cycles;
    do_req(32'd1, 1'b1, 16'd19, 32'd9, 20'd137, 1'b0, 25);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 req = 1'b1; base = 32'd77;
      @(posedge clk); #1 req = 1'b0;
    end
    wait_empty(100);
    check("t5_rgo_pulses", 64'(rgo_cycles - rgo_before), 64'd1);

    // 6: saturated counts with wrapping base
    for (int i = 0; i < 16; i++) cnt_mem[i] = 16'hFFFF;
    do_req(32'hFFFF_FFF8, 1'b1, 16'hFFFF, 32'hFFFF_FFF8, 20'hFFFF0, 1'b0, 25);
    wait_empty(100);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
